// File: rtl/ysyx_22050243_lsu.sv
// Load/store unit: one request in, one doubleword memory access, one response out.
// Optional macro YSYX_22050243_LSU_MISALIGN_TRAP_EN suppresses misaligned accesses and flags them.
module ysyx_22050243_lsu (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_wen,
   input  logic [1:0]  in_size,
   input  logic        in_unsigned,
   input  logic [63:0] in_addr,
   input  logic [63:0] in_wdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_rdata,
   output logic        out_misalign,
   output logic        data_r_en,
   output logic        data_w_en,
   output logic [7:0]  data_wmask,
   output logic [63:0] data_addr,
   output logic [63:0] data_w,
   input  logic [63:0] data_r
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

   state_t      state, state_nxt;
   logic        wen_q, uns_q, misalign_q;
   logic [1:0]  size_q;
   logic [63:0] addr_q, wdata_q, rdata_q;

   logic        acc, trap, sgn;
   logic [2:0]  off;
   logic [5:0]  sh;
   logic [7:0]  base;
   logic [15:0] mask16;
   logic [63:0] shifted, ext;

   assign in_ready     = (state == IDLE) && !rst;
   assign out_valid    = (state == RESP);
   assign out_rdata    = rdata_q;
   assign out_misalign = misalign_q;

   assign off = addr_q[2:0];
   assign sh  = {off, 3'b000};
   assign acc = (state == ACCESS) && !rst;

`ifdef YSYX_22050243_LSU_MISALIGN_TRAP_EN
   logic mis;
   always_comb begin
      mis = 1'b0;
      case (size_q)
         2'd1:    mis = addr_q[0];
         2'd2:    mis = |addr_q[1:0];
         2'd3:    mis = |addr_q[2:0];
         default: mis = 1'b0;
      endcase
   end
   assign trap = mis;
`else
   assign trap = 1'b0;
`endif

   always_comb begin
      base = 8'h01;
      case (size_q)
         2'd0:    base = 8'h01;
         2'd1:    base = 8'h03;
         2'd2:    base = 8'h0F;
         default: base = 8'hFF;
      endcase
   end

   assign mask16 = {8'h00, base} << off;

   // Arithmetic shift makes lanes past the doubleword read as the sign of lane 7,
   // so a crossing signed load extends from its highest in-range byte.
   assign sgn     = !uns_q && (size_q != 2'd3);
   assign shifted = sgn ? 64'($signed(data_r) >>> sh) : (data_r >> sh);

   always_comb begin
      ext = shifted;
      case (size_q)
         2'd0:    ext = {{56{sgn & shifted[7]}},  shifted[7:0]};
         2'd1:    ext = {{48{sgn & shifted[15]}}, shifted[15:0]};
         2'd2:    ext = {{32{sgn & shifted[31]}}, shifted[31:0]};
         default: ext = shifted;
      endcase
   end

   assign data_r_en  = acc && !wen_q && !trap;
   assign data_w_en  = acc &&  wen_q && !trap;
   assign data_addr  = acc ? {addr_q[63:3], 3'b000} : '0;
   assign data_wmask = (acc && !trap) ? mask16[7:0] : '0;
   assign data_w     = (acc && !trap) ? (wdata_q << sh) : '0;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid && in_ready) state_nxt = ACCESS;
         ACCESS:  state_nxt = RESP;
         RESP:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         wen_q      <= 1'b0;
         uns_q      <= 1'b0;
         size_q     <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         misalign_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && in_valid) begin
            wen_q   <= in_wen;
            uns_q   <= in_unsigned;
            size_q  <= in_size;
            addr_q  <= in_addr;
            wdata_q <= in_wdata;
         end
         if (state == ACCESS) begin
            rdata_q    <= (wen_q || trap) ? '0 : ext;
            misalign_q <= trap;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22050243_lsu.sv
// Randomised bench for ysyx_22050243_lsu with a byte-level memory reference model.
// Mirrors YSYX_22050243_LSU_MISALIGN_TRAP_EN when deciding misaligned-access expectations.
module tb_ysyx_22050243_lsu;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, in_wen, in_unsigned;
   logic [1:0]  in_size;
   logic [63:0] in_addr, in_wdata;
   logic        out_valid, out_ready, out_misalign;
   logic [63:0] out_rdata;
   logic        data_r_en, data_w_en;
   logic [7:0]  data_wmask;
   logic [63:0] data_addr, data_w, data_r;

   always #5 clk = ~clk;

   ysyx_22050243_lsu dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_wen(in_wen), .in_size(in_size), .in_unsigned(in_unsigned),
      .in_addr(in_addr), .in_wdata(in_wdata), .out_valid(out_valid),
      .out_ready(out_ready), .out_rdata(out_rdata), .out_misalign(out_misalign),
      .data_r_en(data_r_en), .data_w_en(data_w_en), .data_wmask(data_wmask),
      .data_addr(data_addr), .data_w(data_w), .data_r(data_r)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory seen by the DUT, and an independent byte-addressed reference copy.
   logic [63:0] mem [32];
   logic [7:0]  ref_mem [256];

   assign data_r = data_r_en ? mem[data_addr[7:3]] : 64'hA5A5_5A5A_0F0F_F0F0;

   always @(posedge clk) begin
      logic [63:0] nw;
      if (data_w_en) begin
         nw = mem[data_addr[7:3]];
         for (int j = 0; j < 8; j++)
            if (data_wmask[j]) nw[8*j +: 8] = data_w[8*j +: 8];
         mem[data_addr[7:3]] <= nw;
      end
   end

   function automatic logic [63:0] ref_word(input int w);
      logic [63:0] v;
      for (int j = 0; j < 8; j++) v[8*j +: 8] = ref_mem[w*8 + j];
      return v;
   endfunction

   function automatic logic is_mis(input logic [63:0] a, input logic [1:0] sz);
      int nb = 1 << sz;
      return (int'(a[2:0]) % nb) != 0;
   endfunction

   function automatic logic [63:0] f_load(input logic [63:0] a, input logic [1:0] sz, input logic u);
      int nb = 1 << sz;
      int off = int'(a[2:0]);
      int bw = int'(a[7:3]) * 8;
      logic sg = !u && (sz != 2'd3);
      logic [7:0] fill;
      logic [63:0] v = '0;
      fill = (sg && ref_mem[bw + 7][7]) ? 8'hFF : 8'h00;
      for (int i = 0; i < 8; i++)
         if (i < nb) v[8*i +: 8] = (off + i < 8) ? ref_mem[bw + off + i] : fill;
      if (sg && nb < 8 && v[8*nb - 1])
         for (int i = 0; i < 8; i++)
            if (i >= nb) v[8*i +: 8] = 8'hFF;
      return v;
   endfunction

   // Reference model state: 0 idle, 1 memory access, 2 response pending.
   int          phase = 0;
   int          cyc = 0;
   bit          acc_flag = 0;
   int          acc_cyc_q[$];
   logic        p_wen, p_uns, p_trap;
   logic [1:0]  p_size;
   logic [63:0] p_addr, p_wdata;
   logic [63:0] exp_rdata, exp_addr, exp_w;
   logic [7:0]  exp_mask;

   always @(posedge clk) begin
      int nb, off;
      cyc++;
      if (rst) phase = 0;
      else begin
         case (phase)
            0: if (in_valid) begin
               p_wen = in_wen; p_uns = in_unsigned; p_size = in_size;
               p_addr = in_addr; p_wdata = in_wdata;
`ifdef YSYX_22050243_LSU_MISALIGN_TRAP_EN
               p_trap = is_mis(in_addr, in_size);
`else
               p_trap = 1'b0;
`endif
               nb = 1 << p_size;
               off = int'(p_addr[2:0]);
               exp_addr = p_addr & ~64'h7;
               exp_mask = '0;
               exp_w = '0;
               for (int i = 0; i < 8; i++) begin
                  if (i < nb && off + i < 8) exp_mask[off + i] = 1'b1;
                  if (i >= off) exp_w[8*i +: 8] = p_wdata[8*(i - off) +: 8];
               end
               exp_rdata = (p_wen || p_trap) ? '0 : f_load(p_addr, p_size, p_uns);
               acc_cyc_q.push_back(cyc);
               acc_flag = 1;
               phase = 1;
            end
            1: begin
               if (p_wen && !p_trap) begin
                  nb = 1 << p_size;
                  off = int'(p_addr[2:0]);
                  for (int i = 0; i < 8; i++)
                     if (i < nb && off + i < 8)
                        ref_mem[int'(p_addr[7:3])*8 + off + i] = p_wdata[8*i +: 8];
               end
               phase = 2;
            end
            default: if (out_ready) phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      chk64("in_ready", 64'(in_ready), 64'(phase == 0 && !rst));
      chk64("out_valid", 64'(out_valid), 64'(phase == 2));
      if (phase == 2) begin
         chk64("out_rdata", out_rdata, exp_rdata);
         chk64("out_misalign", 64'(out_misalign), 64'(p_trap));
      end
      if (phase == 1 && !rst) begin
         chk64("data_r_en", 64'(data_r_en), 64'(!p_wen && !p_trap));
         chk64("data_w_en", 64'(data_w_en), 64'(p_wen && !p_trap));
         if (!p_trap) begin
            chk64("data_addr", data_addr, exp_addr);
            chk64("data_wmask", 64'(data_wmask), 64'(exp_mask));
            chk64("data_w", data_w, exp_w);
         end
      end else if (phase == 1) begin
         chk64("rst_gate_en", 64'({data_r_en, data_w_en}), 64'd0);
      end else begin
         chk64("port_quiet", 64'(data_r_en | data_w_en | (|data_wmask) | (|data_addr) | (|data_w)), 64'd0);
      end
   end

   task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                        input logic [63:0] a, input logic [63:0] d, input bit hold);
      bit ok = 0;
      in_wen = w; in_size = sz; in_unsigned = u; in_addr = a; in_wdata = d;
      in_valid = 1'b1;
      acc_flag = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         if (acc_flag) begin ok = 1; break; end
      end
      chk64("accept_timeout", 64'(ok), 64'd1);
      if (!hold) begin
         in_valid = 1'b0;
         in_wen = 1'($urandom); in_size = 2'($urandom); in_unsigned = 1'($urandom);
         in_addr = {$urandom, $urandom}; in_wdata = {$urandom, $urandom};
      end
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (phase == 0) begin ok = 1; break; end
      end
      chk64("idle_timeout", 64'(ok), 64'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      logic [63:0] orig;
      logic [63:0] a, d;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_wen = 0; in_size = 0; in_unsigned = 0; in_addr = '0; in_wdata = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
      for (int j = 0; j < 8; j++) ref_mem[j] = 8'(64'hCAFE_F00D_8000_4455 >> (8*j));
      for (int w = 0; w < 32; w++) mem[w] = ref_word(w);
      repeat (3) @(posedge clk);
      #1;
      chk64("reset_rdata", out_rdata, 64'd0);
      chk64("reset_misalign", 64'(out_misalign), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      issue(1'b0, 2'd0, 1'b0, 64'h8000_0003, '0, 0);
      chk64("pin_lb", exp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
      wait_idle();
      issue(1'b0, 2'd0, 1'b1, 64'h8000_0003, '0, 0);
      chk64("pin_lbu", exp_rdata, 64'h0000_0000_0000_0080);
      wait_idle();

      issue(1'b1, 2'd1, 1'b0, 64'h8000_0006, 64'h1234, 0);
      chk64("pin_sh_mask", 64'(exp_mask), 64'hC0);
      chk64("pin_sh_w", exp_w, 64'h1234_0000_0000_0000);
      wait_idle();
      chk64("sh_mem", mem[0], 64'h1234_F00D_8000_4455);

      for (int j = 0; j < 8; j++) ref_mem[8 + j] = 8'(64'h0123_4567_89AB_CDEF >> (8*j));
      mem[1] = 64'h0123_4567_89AB_CDEF;
      out_ready = 1'b0;
      issue(1'b0, 2'd3, 1'b0, 64'h8000_0008, '0, 0);
      chk64("pin_ld", exp_rdata, 64'h0123_4567_89AB_CDEF);
      repeat (6) begin @(posedge clk); #1; end
      out_ready = 1'b1;
      wait_idle();

      issue(1'b0, 2'd2, 1'b0, 64'h8000_0002, '0, 0);
`ifdef YSYX_22050243_LSU_MISALIGN_TRAP_EN
      chk64("pin_lw_mis", exp_rdata, 64'd0);
`else
      chk64("pin_lw_mis", exp_rdata, 64'hFFFF_FFFF_F00D_8000);
`endif
      wait_idle();

      orig = mem[2];
      issue(1'b1, 2'd3, 1'b0, 64'h8000_0010, 64'hDEAD_BEEF_0000_0001, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk64("sd_reset_mem", mem[2], orig);
      chk64("sd_reset_ref", ref_word(2), orig);
      issue(1'b0, 2'd3, 1'b0, 64'h8000_0010, '0, 0);
      wait_idle();

      acc_cyc_q.delete();
      for (int k = 0; k < 6; k++)
         issue(1'($urandom), 2'($urandom), 1'($urandom),
               {$urandom, $urandom}, {$urandom, $urandom}, 1);
      in_valid = 1'b0;
      wait_idle();
      for (int k = 1; k < acc_cyc_q.size(); k++)
         chk64("b2b_spacing", 64'(acc_cyc_q[k] - acc_cyc_q[k-1]), 64'd3);

      for (int k = 0; k < 150; k++) begin
         a = {$urandom, $urandom};
         d = {$urandom, $urandom};
         out_ready = 1'($urandom);
         issue(1'($urandom), 2'($urandom), 1'($urandom), a, d, 0);
         if (!out_ready) begin
            repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
            out_ready = 1'b1;
         end
         wait_idle();
      end

      for (int w = 0; w < 32; w++) chk64("final_mem", mem[w], ref_word(w));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
